acc_bank_array: RTL and testbench
=================================

# acc_bank_array

Parametrised multi-column accumulator bank between the systolic array's partial-sum outputs and the PPU. Each column holds DEPTH signed accumulators and takes one read-modify-write per column per cycle. Operations are overwrite, accumulate or clear, and back-to-back same-row hazards are forwarded. Optional saturating arithmetic sets sticky per-column overflow flags. A drain engine streams all rows to the PPU over a valid/ready handshake, optionally zeroing each row after it is read.

## Interface
- NUM_COLS, 12: number of columns (independent banks sharing one address).
- DEPTH, 12: rows per column; need not be a power of two.
- ADDR_W, 4: address width; must satisfy 2^ADDR_W >= DEPTH.
- IN_WIDTH, 24: signed partial-sum width; must be <= ACC_WIDTH.
- ACC_WIDTH, 32: signed accumulator width.
- SATURATE, 1: 1 clamps on overflow; 0 wraps (two's complement).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE.
- in_addr  in  ADDR_W  row index.
- in_mode  in  2  00 overwrite, 01 accumulate, 10 clear row, 11 no-op.
- in_psum  in  NUM_COLS*IN_WIDTH  column c at bits [c*IN_WIDTH +: IN_WIDTH].
- drain_start  in  1  pulse; request a full readout.
- drain_clear  in  1  sampled with drain_start; 1 zeroes each row after it is emitted.
- out_valid  out  1  drain data valid.
- out_ready  in  1  PPU accepts.
- out_data  out  NUM_COLS*ACC_WIDTH  one row, same packing.
- out_row  out  ADDR_W  row index of out_data.
- out_last  out  1  high with row DEPTH-1.
- busy  out  1  high in INIT/DRAIN or while the RMW pipeline holds an operation.
- sat_flag  out  NUM_COLS  sticky per-column saturation/overflow.
- addr_err  out  1  sticky; an operation had in_addr >= DEPTH.

## Operation
- FSM states: INIT, IDLE, DRAIN.
- INIT is entered on rst. It writes zero to rows 0..DEPTH-1, one row per cycle, then goes to IDLE.
- IDLE: an operation is accepted when in_valid & in_ready. A drain is accepted when drain_start is high and the RMW pipeline is empty; acceptance moves the FSM to DRAIN.
- drain_start has priority over in_valid in the same cycle. The operation is not accepted; in_ready is already low that cycle because of combinational dependence on drain_start.
- Accept of drain_start clears sat_flag and addr_err.
- DRAIN emits rows 0..DEPTH-1 in order, one row per handshake. After the out_last handshake the FSM returns to IDLE.
- If drain_clear was latched, each row is written to zero in the cycle its handshake completes.
- The RMW is two-stage and memory read is synchronous.
  - Stage 1: register the op and issue the read.
  - Stage 2: compute and write.
- Arithmetic per column: in_psum is sign-extended to ACC_WIDTH. Accumulate computes old + psum at ACC_WIDTH+1 bits.
  - SATURATE=1: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and set sat_flag[c] on clamp.
  - SATURATE=0: keep the low ACC_WIDTH bits and set sat_flag[c] on signed overflow.
- Forwarding: when stage 2 writes row r and stage 1 reads row r in the same cycle, stage 1 uses stage 2's write value, not the memory output.
- An operation with in_addr >= DEPTH is accepted and dropped (no write) and sets addr_err.
- Mode 11 is accepted and performs no write.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_row=0, out_last=0, busy=1, sat_flag=0, addr_err=0.
- INIT lasts exactly DEPTH cycles after rst deasserts; in_ready rises in cycle DEPTH+1.
- An op accepted in cycle N writes memory at the end of cycle N+1.
  - An op to the same row in N+1 sees it via forwarding.
  - An op in N+2 or later sees it via memory.
- Throughput is one op per cycle per column with no bubbles.
- Drain: the first out_valid appears at most 2 cycles after drain_start is accepted.
- Once out_valid is high, out_data, out_row and out_last stay stable until out_ready.
- With out_ready held high, one row is emitted per cycle and the drain takes DEPTH+2 cycles at most.
- rst asserted mid-drain or mid-op: the transfer is aborted, out_valid drops the next cycle, and INIT re-zeroes all rows.

## Test plan
- After rst, count cycles: in_ready rises after exactly DEPTH=12 cycles. An immediate drain then returns twelve all-zero rows with out_last on row 11.
- Overwrite row 3 with 100 in every column, then accumulate -30 twice back-to-back. Drain gives 40 in row 3, which exercises forwarding.
- SATURATE=1: overwrite row 0 with 2^31-10, then accumulate 20. Drain gives 2^31-1 and sat_flag=all-ones. A second drain_start clears sat_flag to 0.
- Drain with out_ready toggled 1,0,0,1 in a repeating pattern: every row is delivered once, in order, with data stable while stalled. With drain_clear=1, a second drain returns all zeros.
- in_addr=13 with DEPTH=12: addr_err=1 and no row changes. Assert rst during the row-5 handshake: out_valid is 0 next cycle and a later drain returns zeros.

Source files
------------

// File: rtl/acc_bank_array.sv
// acc_bank_array: multi-column signed accumulator bank.
// All columns share one row address. Each cycle a two-stage read-modify-write
// can overwrite, accumulate or clear one row. A drain engine streams every row
// to the PPU over valid/ready and can zero each row once it has been emitted.
module acc_bank_array #(
  parameter int unsigned NUM_COLS  = 12,
  parameter int unsigned DEPTH     = 12,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned ACC_WIDTH = 32,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic [1:0]                    in_mode,
  input  logic [NUM_COLS*IN_WIDTH-1:0]  in_psum,
  input  logic                          drain_start,
  input  logic                          drain_clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_COLS*ACC_WIDTH-1:0] out_data,
  output logic [ADDR_W-1:0]             out_row,
  output logic                          out_last,
  output logic                          busy,
  output logic [NUM_COLS-1:0]           sat_flag,
  output logic                          addr_err
);

  localparam int unsigned       ROW_W     = NUM_COLS * ACC_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   PTR_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH - 1){1'b0}}};

  localparam logic [1:0] MODE_WRITE = 2'b00;
  localparam logic [1:0] MODE_ACC   = 2'b01;
  localparam logic [1:0] MODE_NOP   = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e state_q;
  logic [ADDR_W-1:0] init_row_q;

  // Row storage; every column of a row lives in one wide word.
  logic [ROW_W-1:0] mem_q [DEPTH];

  // Stage 1 registers of the read-modify-write pipeline.
  logic                          s1_valid_q;
  logic                          s1_we_q;
  logic [ADDR_W-1:0]             s1_addr_q;
  logic [1:0]                    s1_mode_q;
  logic [NUM_COLS*IN_WIDTH-1:0]  s1_psum_q;

  // Synchronous read data, shared by the op pipeline and the drain prefetch.
  logic [ROW_W-1:0] rd_q;
  logic             rd_vld_q;
  logic [ADDR_W:0]  fetch_ptr_q;
  logic             clear_q;

  logic                out_valid_q;
  logic [ROW_W-1:0]    out_data_q;
  logic [ADDR_W-1:0]   out_row_q;
  logic                out_last_q;
  logic [NUM_COLS-1:0] sat_q;
  logic                addr_err_q;

  logic                op_acc;
  logic                drain_acc;
  logic                addr_ok;
  logic                consume;
  logic                fetch_issue;
  logic [ADDR_W-1:0]   rd_row;
  logic [ROW_W-1:0]    s2_row;
  logic [NUM_COLS-1:0] s2_ovf;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ROW_W-1:0]    wr_data;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;

  assign in_ready  = (state_q == ST_IDLE) && !drain_start;
  assign op_acc    = in_valid && in_ready;
  assign drain_acc = (state_q == ST_IDLE) && drain_start && !s1_valid_q;
  assign addr_ok   = ({1'b0, in_addr} < PTR_DEPTH);

  // rd_q always holds row fetch_ptr_q-1 while a drain prefetch is pending.
  assign rd_row      = ADDR_W'(fetch_ptr_q - 1'b1);
  assign consume     = rd_vld_q && (!out_valid_q || out_ready);
  assign fetch_issue = (state_q == ST_DRAIN) && (fetch_ptr_q < PTR_DEPTH) &&
                       (!rd_vld_q || consume);

  // Stage 2: per-column arithmetic on the read (or forwarded) row.
  always_comb begin
    logic [ACC_WIDTH-1:0] old_v;
    logic [ACC_WIDTH-1:0] ext_v;
    logic [ACC_WIDTH-1:0] res_v;
    logic [ACC_WIDTH:0]   sum_v;
    s2_row = '0;
    s2_ovf = '0;
    old_v  = '0;
    ext_v  = '0;
    res_v  = '0;
    sum_v  = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      old_v = rd_q[c*ACC_WIDTH +: ACC_WIDTH];
      ext_v = ACC_WIDTH'($signed(s1_psum_q[c*IN_WIDTH +: IN_WIDTH]));
      sum_v = {old_v[ACC_WIDTH-1], old_v} + {ext_v[ACC_WIDTH-1], ext_v};
      case (s1_mode_q)
        MODE_WRITE: res_v = ext_v;
        MODE_ACC: begin
          res_v = sum_v[ACC_WIDTH-1:0];
          if (sum_v[ACC_WIDTH] != sum_v[ACC_WIDTH-1]) begin
            s2_ovf[c] = 1'b1;
            if (SATURATE) begin
              res_v = sum_v[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            end
          end
        end
        default: res_v = '0;
      endcase
      s2_row[c*ACC_WIDTH +: ACC_WIDTH] = res_v;
    end
  end

  // Single write port: init zeroing, drain clear-after-read, or stage-2 result.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = init_row_q;
    end else if ((state_q == ST_DRAIN) && out_valid_q && out_ready && clear_q) begin
      wr_en   = 1'b1;
      wr_addr = out_row_q;
    end else if (s1_we_q) begin
      wr_en   = 1'b1;
      wr_addr = s1_addr_q;
      wr_data = s2_row;
    end
  end

  // Single read port: drain start, drain prefetch, or stage-1 op read.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (drain_acc) begin
      rd_en = 1'b1;
    end else if (fetch_issue) begin
      rd_en   = 1'b1;
      rd_addr = fetch_ptr_q[ADDR_W-1:0];
    end else if (op_acc && addr_ok) begin
      rd_en   = 1'b1;
      rd_addr = in_addr;
    end
  end

  // Row memory with same-cycle write-to-read forwarding.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_q <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
    end
  end

  // Control FSM, op pipeline stage 1, drain output register and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_row_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_we_q     <= 1'b0;
      s1_addr_q   <= '0;
      s1_mode_q   <= MODE_NOP;
      s1_psum_q   <= '0;
      rd_vld_q    <= 1'b0;
      fetch_ptr_q <= '0;
      clear_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
      sat_q       <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      s1_valid_q <= op_acc;
      s1_we_q    <= op_acc && addr_ok && (in_mode != MODE_NOP);
      s1_addr_q  <= in_addr;
      s1_mode_q  <= in_mode;
      s1_psum_q  <= in_psum;
      if (s1_we_q) begin
        sat_q <= sat_q | s2_ovf;
      end
      if (op_acc && !addr_ok) begin
        addr_err_q <= 1'b1;
      end
      case (state_q)
        ST_INIT: begin
          init_row_q <= init_row_q + 1'b1;
          if (init_row_q == LAST_ROW) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (drain_acc) begin
            state_q     <= ST_DRAIN;
            clear_q     <= drain_clear;
            sat_q       <= '0;
            addr_err_q  <= 1'b0;
            rd_vld_q    <= 1'b1;
            fetch_ptr_q <= (ADDR_W + 1)'(1);
          end
        end
        ST_DRAIN: begin
          if (fetch_issue) begin
            fetch_ptr_q <= fetch_ptr_q + 1'b1;
            rd_vld_q    <= 1'b1;
          end else if (consume) begin
            rd_vld_q <= 1'b0;
          end
          if (!out_valid_q || out_ready) begin
            out_valid_q <= rd_vld_q;
            if (rd_vld_q) begin
              out_data_q <= rd_q;
              out_row_q  <= rd_row;
              out_last_q <= (rd_row == LAST_ROW);
            end
          end
          if (out_valid_q && out_ready && out_last_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE) || s1_valid_q;
  assign sat_flag  = sat_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_acc_bank_array.sv
// Bench for acc_bank_array: a row/column model of the bank updated at each
// accepted op, checked against every drained row, plus literal expectations.
module tb_acc_bank_array;

  localparam int NC   = 12;
  localparam int DP   = 12;
  localparam int AW   = 4;
  localparam int IW   = 24;
  localparam int ACW  = 32;
  localparam bit SAT  = 1'b1;
  localparam int ROWW = NC * ACW;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     in_addr;
  logic [1:0]        in_mode;
  logic [NC*IW-1:0]  in_psum;
  logic              drain_start;
  logic              drain_clear;
  logic              out_valid;
  logic              out_ready;
  logic [ROWW-1:0]   out_data;
  logic [AW-1:0]     out_row;
  logic              out_last;
  logic              busy;
  logic [NC-1:0]     sat_flag;
  logic              addr_err;

  acc_bank_array #(
    .NUM_COLS (NC),
    .DEPTH    (DP),
    .ADDR_W   (AW),
    .IN_WIDTH (IW),
    .ACC_WIDTH(ACW),
    .SATURATE (SAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_mode    (in_mode),
    .in_psum    (in_psum),
    .drain_start(drain_start),
    .drain_clear(drain_clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_last   (out_last),
    .busy       (busy),
    .sat_flag   (sat_flag),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  longint        mdl_mem [DP][NC];
  logic [NC-1:0] mdl_sat;
  logic          mdl_err;
  logic          mdl_clear;
  int            exp_row;
  int            rows_seen;
  logic [ROWW-1:0] got [DP];

  task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [ROWW-1:0] mdl_row(input int r);
    logic [ROWW-1:0] v;
    longint e;
    v = '0;
    for (int c = 0; c < NC; c++) begin
      e = mdl_mem[r][c];
      v[c*ACW +: ACW] = e[ACW-1:0];
    end
    return v;
  endfunction

  task automatic mdl_zero();
    for (int r = 0; r < DP; r++)
      for (int c = 0; c < NC; c++)
        mdl_mem[r][c] = 0;
    mdl_sat = '0;
    mdl_err = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic pat(input bit toggle, input int n);
    if (!toggle) return 1'b1;
    return ((n % 4) == 0) || ((n % 4) == 3);
  endfunction

  // Issue one op (held for exactly one cycle unless the next call follows).
  task automatic do_op(input int addr, input logic [1:0] mode, input int base, input int stp);
    int v;
    longint s;
    logic [31:0] w;
    step();
    in_valid = 1'b1;
    in_addr  = AW'(addr);
    in_mode  = mode;
    for (int c = 0; c < NC; c++) begin
      v = base + c * stp;
      in_psum[c*IW +: IW] = v[IW-1:0];
    end
    #1 chk("op_ready", {399'd0, in_ready}, 400'd1);
    if (addr >= DP) begin
      mdl_err = 1'b1;
    end else begin
      for (int c = 0; c < NC; c++) begin
        v = base + c * stp;
        case (mode)
          2'b00: mdl_mem[addr][c] = longint'(v);
          2'b01: begin
            s = mdl_mem[addr][c] + longint'(v);
            if (s > MAXV || s < MINV) begin
              mdl_sat[c] = 1'b1;
              if (SAT) s = (s > MAXV) ? MAXV : MINV;
              else begin
                w = s[31:0];
                s = longint'($signed(w));
              end
            end
            mdl_mem[addr][c] = s;
          end
          2'b10: mdl_mem[addr][c] = 0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic idle();
    step();
    in_valid = 1'b0;
    in_mode  = 2'b11;
    step();
    step();
    chk("idle_busy", {399'd0, busy}, 400'd0);
  endtask

  task automatic start_drain(input bit clr);
    step();
    drain_start = 1'b1;
    drain_clear = clr;
    out_ready   = 1'b1;
    exp_row     = 0;
    rows_seen   = 0;
    mdl_clear   = clr;
    mdl_sat     = '0;
    mdl_err     = 1'b0;
    #1 chk("ready_low_on_drain", {399'd0, in_ready}, 400'd0);
  endtask

  task automatic do_drain(input bit clr, input bit toggle);
    int n;
    start_drain(clr);
    step();
    n = 1;
    drain_start = 1'b0;
    drain_clear = 1'b0;
    out_ready   = pat(toggle, n);
    step();
    n = 2;
    out_ready = pat(toggle, n);
    chk("first_valid_lat", {399'd0, out_valid}, 400'd1);
    while (busy && n < 200) begin
      step();
      n++;
      out_ready = pat(toggle, n);
    end
    out_ready = 1'b1;
    chk("drain_done", {399'd0, busy}, 400'd0);
    chk("rows_delivered", 400'(rows_seen), 400'(DP));
    chk("flags_after_drain", {387'd0, addr_err, sat_flag}, {387'd0, mdl_err, mdl_sat});
    if (!toggle) chk("drain_cycles_bound", {399'd0, (n <= DP + 2)}, 400'd1);
  endtask

  // Compare process: every drained row against the model, and hold while stalled.
  logic            have_prev;
  logic            prev_v, prev_r;
  logic [399:0]    prev_b;
  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_v && !prev_r)
        chk("stall_hold", {10'd0, out_valid, out_last, out_row, out_data}, prev_b);
      if (out_valid && out_ready) begin
        chk("row_idx", 400'(out_row), 400'(exp_row));
        chk("row_last", {399'd0, out_last}, {399'd0, (exp_row == DP - 1)});
        if (exp_row < DP) begin
          chk("row_data", 400'(out_data), 400'(mdl_row(exp_row)));
          got[exp_row] = out_data;
          if (mdl_clear)
            for (int c = 0; c < NC; c++) mdl_mem[exp_row][c] = 0;
        end
        exp_row++;
        rows_seen++;
      end
      have_prev = 1'b1;
      prev_v = out_valid;
      prev_r = out_ready;
      prev_b = {10'd0, out_valid, out_last, out_row, out_data};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_addr = '0;
    in_mode = 2'b11;
    in_psum = '0;
    drain_start = 1'b0;
    drain_clear = 1'b0;
    out_ready = 1'b1;
    exp_row = 0;
    rows_seen = 0;
    mdl_clear = 1'b0;
    have_prev = 1'b0;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_b = '0;
    mdl_zero();

    // Reset values
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst_in_ready", {399'd0, in_ready}, 400'd0);
    chk("rst_out_valid", {399'd0, out_valid}, 400'd0);
    chk("rst_out_data", 400'(out_data), 400'd0);
    chk("rst_out_row", 400'(out_row), 400'd0);
    chk("rst_out_last", {399'd0, out_last}, 400'd0);
    chk("rst_busy", {399'd0, busy}, 400'd1);
    chk("rst_sat", 400'(sat_flag), 400'd0);
    chk("rst_addr_err", {399'd0, addr_err}, 400'd0);

    // INIT length: in_ready rises in cycle DEPTH+1 after rst deasserts
    rst = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (in_ready) break;
    end
    chk("init_cycles", 400'(n), 400'(DP + 1));

    // Immediate drain returns zeros
    do_drain(1'b0, 1'b0);
    chk("init_row11_zero", 400'(got[11]), 400'd0);

    // Overwrite/accumulate with forwarding (N+1) and memory path (N+2)
    do_op(3, 2'b00, 100, 0);
    do_op(3, 2'b01, -30, 0);
    do_op(3, 2'b01, -30, 0);
    do_op(5, 2'b00, -6000, 1000);
    do_op(5, 2'b01, 7, -3);
    do_op(7, 2'b00, 55, 0);
    do_op(5, 2'b01, -1, 1);
    do_op(7, 2'b11, 999, 0);
    do_op(9, 2'b00, -5, 2);
    do_op(9, 2'b10, 0, 0);
    idle();
    do_drain(1'b0, 1'b0);
    chk("row3_lit", 400'(got[3]), 400'({NC{32'd40}}));
    chk("row7_nop_lit", 400'(got[7]), 400'({NC{32'd55}}));
    chk("row9_clr_lit", 400'(got[9]), 400'd0);

    // Saturation, positive and negative
    do_op(0, 2'b00, 8388607, 0);
    for (int i = 0; i < 255; i++) do_op(0, 2'b01, 8388607, 0);
    do_op(0, 2'b01, 246, 0);
    do_op(0, 2'b01, 20, 0);
    do_op(1, 2'b00, -8388608, 0);
    for (int i = 0; i < 256; i++) do_op(1, 2'b01, -8388608, 0);
    idle();
    chk("sat_model", 400'(sat_flag), 400'(mdl_sat));
    chk("sat_lit", 400'(sat_flag), 400'h fff);
    chk("sat_no_addr_err", {399'd0, addr_err}, 400'd0);
    do_drain(1'b0, 1'b0);
    chk("row0_max_lit", 400'(got[0]), 400'({NC{32'h7fffffff}}));
    chk("row1_min_lit", 400'(got[1]), 400'({NC{32'h80000000}}));
    chk("sat_cleared_lit", 400'(sat_flag), 400'd0);

    // Stalled drain with clear, then all zeros
    do_drain(1'b1, 1'b1);
    chk("stall_row3_lit", 400'(got[3]), 400'({NC{32'd40}}));
    do_drain(1'b0, 1'b0);
    chk("cleared_row0_lit", 400'(got[0]), 400'd0);

    // Out-of-range address
    do_op(2, 2'b00, 11, 0);
    do_op(13, 2'b00, 777, 0);
    idle();
    chk("addr_err_model", {399'd0, addr_err}, {399'd0, mdl_err});
    chk("addr_err_lit", {399'd0, addr_err}, 400'd1);
    do_drain(1'b0, 1'b0);
    chk("row2_lit", 400'(got[2]), 400'({NC{32'd11}}));
    chk("addr_err_cleared", {399'd0, addr_err}, 400'd0);

    // Reset during the row-5 handshake
    do_op(8, 2'b00, 88, 0);
    idle();
    start_drain(1'b0);
    step();
    drain_start = 1'b0;
    n = 0;
    while (!(out_valid && out_row == 4'd5) && n < 50) begin
      step();
      n++;
    end
    chk("reach_row5", 400'(out_row), 400'd5);
    rst = 1'b1;
    step();
    chk("abort_valid_drop", {399'd0, out_valid}, 400'd0);
    rst = 1'b0;
    mdl_zero();
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("reinit_ready", {399'd0, in_ready}, 400'd1);
    do_drain(1'b0, 1'b0);
    chk("post_rst_row8_lit", 400'(got[8]), 400'd0);
    chk("post_rst_row2_lit", 400'(got[2]), 400'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
